// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the full-subtractor borrow equation.
package sub_serial_pkg;

    localparam int SS_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SUB  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4,
        ST_DCY0 = 3'd5,
        ST_DCY1 = 3'd6,
        ST_DCY2 = 3'd7
    } ss_state_t;

    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~x & bin) | (y & bin);
    endfunction

endpackage

// File: rtl/sub_serial_bit.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module sub_serial_bit
    import sub_serial_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = fs_borrow(x, y, bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial 8-bit subtractor (a - b), LSB first, with XOR-scrambled operands
// and decoy FSM states that rejoin the legal flow.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter logic [7:0] A_MASK = 8'h00,
    parameter logic [7:0] B_MASK = 8'h00,
    parameter int         WIDTH  = SS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             done
);

    ss_state_t        r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             r_done;
    logic [2:0]       r_count;

    ss_state_t        w_state_nx;
    logic [WIDTH-1:0] w_a_nx;
    logic [WIDTH-1:0] w_b_nx;
    logic [WIDTH-1:0] w_out_nx;
    logic             w_borrow_nx;
    logic             w_borrow_out_nx;
    logic             w_done_nx;
    logic [2:0]       w_count_nx;
    logic             w_d;
    logic             w_bout;

    sub_serial_bit u_bit (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Next-state and datapath update for every state, decoys included.
    always_comb begin
        w_state_nx      = r_state;
        w_a_nx          = r_a;
        w_b_nx          = r_b;
        w_out_nx        = r_out;
        w_borrow_nx     = r_borrow;
        w_borrow_out_nx = r_borrow_out;
        w_done_nx       = r_done;
        w_count_nx      = r_count;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_a_nx      = a ^ A_MASK;
                    w_b_nx      = b ^ B_MASK;
                    w_out_nx    = '0;
                    w_borrow_nx = 1'b0;
                    w_count_nx  = 3'd0;
                    w_state_nx  = ST_PRE;
                end else begin
                    w_state_nx  = ST_IDLE;
                end
            end
            ST_PRE: begin
                w_state_nx = ST_SUB;
            end
            ST_SUB: begin
                w_borrow_nx = w_bout;
                w_out_nx    = {w_d, r_out[WIDTH-1:1]};
                w_a_nx      = {1'b0, r_a[WIDTH-1:1]};
                w_b_nx      = {1'b0, r_b[WIDTH-1:1]};
                w_count_nx  = r_count + 3'd1;
                if (r_count == 3'd7) begin
                    w_state_nx = ST_POST;
                end else begin
                    w_state_nx = ST_SUB;
                end
            end
            ST_POST: begin
                w_borrow_out_nx = r_borrow;
                w_done_nx       = 1'b1;
                w_state_nx      = ST_DONE;
            end
            ST_DONE: begin
                if (en) begin
                    w_done_nx  = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            // Decoys scramble state but always fall back into SUB or POST.
            ST_DCY0: begin
                w_count_nx = r_count + {a[5], b[5], a[2]};
                w_out_nx   = {r_out[WIDTH-2:0], w_d};
                w_state_nx = ST_DCY1;
            end
            ST_DCY1: begin
                w_borrow_nx = r_a[0] | r_b[0] | r_borrow;
                w_a_nx      = {1'b0, r_a[WIDTH-1:1]};
                w_b_nx      = {1'b0, r_b[WIDTH-1:1]};
                w_state_nx  = ST_SUB;
            end
            ST_DCY2: begin
                w_state_nx = ST_POST;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_out        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= 3'd0;
        end else begin
            r_state      <= w_state_nx;
            r_a          <= w_a_nx;
            r_b          <= w_b_nx;
            r_out        <= w_out_nx;
            r_borrow     <= w_borrow_nx;
            r_borrow_out <= w_borrow_out_nx;
            r_done       <= w_done_nx;
            r_count      <= w_count_nx;
        end
    end

    assign out        = r_out;
    assign borrow_out = r_borrow_out;
    assign done       = r_done;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: two instances (default and non-trivial
// masks) checked against plain modular arithmetic.
module tb_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out0, out1;
    logic       bo0, bo1;
    logic       done0, done1;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [7:0] MA = 8'h08;
    localparam logic [7:0] MB = 8'hFF;

    always #5 clk = ~clk;

    sub_serial #(.A_MASK(8'h00), .B_MASK(8'h00), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .out(out0), .borrow_out(bo0), .done(done0)
    );

    sub_serial #(.A_MASK(MA), .B_MASK(MB), .WIDTH(8)) dut_m (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .out(out1), .borrow_out(bo1), .done(done1)
    );

    // Reference: {borrow, difference mod 256} of already-masked operands.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
        int diff;
        diff = (int'(x) + 256 - int'(y)) % 256;
        return {(x < y), diff[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and gathers observations up to the first DONE cycle.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input bit hold_en,
                          output logic [7:0] o9, output int early,
                          output logic dn0, output logic dn1);
        a  = xa;
        b  = xb;
        en = 1'b1;
        step();
        if (!hold_en) en = 1'b0;
        early = 0;
        o9    = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            step();
            if (k == 9) o9 = out0;
            if (k < 10 && (done0 || done1)) early++;
        end
        dn0 = done0;
        dn1 = done1;
        en  = 1'b0;
    endtask

    task automatic exit_done();
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                            input logic [7:0] o9, input int early,
                            input logic dn0, input logic dn1);
        logic [8:0] e0, e1;
        e0 = ref_sub(xa, xb);
        e1 = ref_sub(xa ^ MA, xb ^ MB);
        n_cmp++; if (out0 !== e0[7:0]) begin n_err++; $display("FAIL %s out: got %h want %h", tag, out0, e0[7:0]); end
        n_cmp++; if (bo0 !== e0[8]) begin n_err++; $display("FAIL %s borrow_out: got %b want %b", tag, bo0, e0[8]); end
        n_cmp++; if (out1 !== e1[7:0]) begin n_err++; $display("FAIL %s masked out: got %h want %h", tag, out1, e1[7:0]); end
        n_cmp++; if (bo1 !== e1[8]) begin n_err++; $display("FAIL %s masked borrow_out: got %b want %b", tag, bo1, e1[8]); end
        n_cmp++; if (o9 !== e0[7:0]) begin n_err++; $display("FAIL %s out at E+9: got %h want %h", tag, o9, e0[7:0]); end
        n_cmp++; if (early !== 0) begin n_err++; $display("FAIL %s early done: got %0d cycles want 0", tag, early); end
        n_cmp++; if ({dn0, dn1} !== 2'b11) begin n_err++; $display("FAIL %s done at E+10: got %b want 11", tag, {dn0, dn1}); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        step();
        step();
        n_cmp++; if ({out0, bo0, done0} !== 10'd0) begin n_err++; $display("FAIL reset dut: got %h want 000", {out0, bo0, done0}); end
        n_cmp++; if ({out1, bo1, done1} !== 10'd0) begin n_err++; $display("FAIL reset dut_m: got %h want 000", {out1, bo1, done1}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [7:0] va [3] = '{8'h5A, 8'h10, 8'h00};
        logic [7:0] vb [3] = '{8'h23, 8'h20, 8'h00};
        logic [7:0] o9;
        int         early;
        logic       d0, d1;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, o9, early, d0, d1);
            check_op("directed", va[i], vb[i], o9, early, d0, d1);
            exit_done();
            n_cmp++; if ({done0, done1} !== 2'b00) begin n_err++; $display("FAIL directed exit done: got %b want 00", {done0, done1}); end
        end
        // Known constants from hand arithmetic.
        n_cmp++; if ({bo1, out1} !== 9'h109) begin n_err++; $display("FAIL masked zero operands: got %h want 109", {bo1, out1}); end
    endtask

    task automatic test_en_held();
        logic [7:0] o9;
        int         early;
        logic       d0, d1;
        run_op(8'hFF, 8'h01, 1'b1, o9, early, d0, d1);
        check_op("en_held", 8'hFF, 8'h01, o9, early, d0, d1);
        n_cmp++; if (out0 !== 8'hFE) begin n_err++; $display("FAIL en_held const: got %h want fe", out0); end
        exit_done();
    endtask

    task automatic test_done_hold();
        logic [7:0] o9, xa, xb, held;
        int         early, unstable;
        logic       d0, d1;
        xa = 8'($urandom);
        xb = 8'($urandom);
        run_op(xa, xb, 1'b0, o9, early, d0, d1);
        check_op("done_hold", xa, xb, o9, early, d0, d1);
        held     = ref_sub(xa, xb);
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            step();
            if (out0 !== held || done0 !== 1'b1 || bo0 !== (xa < xb)) unstable++;
        end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL done_hold stability: got %0d bad cycles want 0", unstable); end
        exit_done();
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL done_hold exit: got %b want 0", done0); end
        for (int k = 0; k < 3; k++) step();
        n_cmp++; if (done0 !== 1'b0 || out0 !== held) begin n_err++; $display("FAIL done_hold idle: got done %b out %h want 0 %h", done0, out0, held); end
        xa = 8'($urandom);
        xb = 8'($urandom);
        run_op(xa, xb, 1'b0, o9, early, d0, d1);
        check_op("done_hold reload", xa, xb, o9, early, d0, d1);
        exit_done();
    endtask

    task automatic test_reset_mid();
        logic [7:0] o9;
        int         early;
        logic       d0, d1;
        a  = 8'hC3;
        b  = 8'h18;
        en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({out0, bo0, done0} !== 10'd0) begin n_err++; $display("FAIL reset_mid async: got %h want 000", {out0, bo0, done0}); end
        step();
        rst = 1'b0;
        step();
        run_op(8'h03, 8'h05, 1'b0, o9, early, d0, d1);
        check_op("reset_mid next", 8'h03, 8'h05, o9, early, d0, d1);
        n_cmp++; if ({bo0, out0} !== 9'h1FE) begin n_err++; $display("FAIL reset_mid const: got %h want 1fe", {bo0, out0}); end
        exit_done();
    endtask

    task automatic test_back_to_back();
        logic [7:0] o9, xa, xb;
        int         early;
        logic       d0, d1;
        for (int i = 0; i < 20; i++) begin
            xa = 8'($urandom);
            xb = 8'($urandom);
            run_op(xa, xb, i[0], o9, early, d0, d1);
            check_op("back_to_back", xa, xb, o9, early, d0, d1);
            exit_done();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_en_held();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
